div_seq_unsigned: RTL and testbench

Parametrised, iterative unsigned divider that computes SBC / SC over several clock cycles using restoring division. Each cycle retires STEP quotient bits. This trades area against latency relative to a full combinational array. The block sits behind any datapath that needs quotient and remainder. It uses a start/done handshake, latches its operands, and flags divide-by-zero.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 28 ++
 rtl/div_seq_unsigned.sv | 125 ++++++++++++
 tb/tb_div_seq_unsigned.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the sequential restoring divider.
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int iter_of(input int width, input int step);
    return width / step;
  endfunction

  function automatic int cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  function automatic bit params_ok(input int width, input int step);
    return (width >= 2) && (step >= 1) && ((width % step) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// One restoring-division sub-step: shift in a dividend bit, trial-subtract the divisor.
`default_nettype none

module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    rem_sh          = {rem_in[WIDTH-1:0], dvd_bit};
    {borrow, diff}  = {1'b0, rem_sh} - {2'b00, divisor};
    // A set top bit means the true shifted remainder exceeds any WIDTH-bit divisor.
    q_bit           = rem_in[WIDTH] | ~borrow;
    rem_out         = q_bit ? diff : rem_sh;
  end

endmodule

`default_nettype wire

// File: rtl/div_seq_unsigned.sv
// Iterative unsigned restoring divider, STEP quotient bits per cycle, start/done handshake.
`default_nettype none

module div_seq_unsigned
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] SBC,
  input  logic [WIDTH-1:0] SC,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int ITER  = iter_of(WIDTH, STEP);
  localparam int CNT_W = cnt_width(ITER);

  if (!params_ok(WIDTH, STEP)) begin : g_bad_params
    $error("div_seq_unsigned: WIDTH must be >= 2 and a multiple of STEP");
  end

  div_state_t             state, state_next;
  logic [WIDTH-1:0]       dvd;
  logic [WIDTH-1:0]       dvs;
  logic [WIDTH:0]         rem;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       q_reg;
  logic [WIDTH-1:0]       r_reg;
  logic                   dz_reg;

  logic [STEP:0][WIDTH:0] rem_chain;
  logic [STEP-1:0]        q_bits;
  logic [WIDTH-1:0]       dvd_next;
  logic                   last;

  assign last         = (cnt == CNT_W'(ITER - 1));
  assign rem_chain[0] = rem;

  for (genvar i = 0; i < STEP; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain[i]),
      .dvd_bit (dvd[WIDTH-1-i]),
      .divisor (dvs),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_bits[STEP-1-i])
    );
  end

  // Quotient bits enter at the bottom as dividend bits leave the top.
  if (STEP < WIDTH) begin : g_shift
    assign dvd_next = {dvd[WIDTH-STEP-1:0], q_bits};
  end else begin : g_full
    assign dvd_next = q_bits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (SC == '0) ? DONE : BUSY;
      BUSY:       if (last)  state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd    <= SBC;
            dvs    <= SC;
            rem    <= '0;
            cnt    <= '0;
            dz_reg <= (SC == '0);
            if (SC == '0) begin
              q_reg <= '1;
              r_reg <= SBC;
            end
          end
        end
        BUSY: begin
          dvd <= dvd_next;
          rem <= rem_chain[STEP];
          cnt <= cnt + 1'b1;
          if (last) begin
            q_reg <= dvd_next;
            r_reg <= rem_chain[STEP][WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == BUSY);
  assign ready = ~busy;
  assign done  = (state == DONE);
  assign dz    = dz_reg;
  assign Q     = q_reg;
  assign R     = r_reg;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_unsigned.sv
// Directed self-checking bench for div_seq_unsigned (8/1 and 16/2 configurations).
`default_nettype none

module tb_div_seq_unsigned;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, ready8, busy8, done8, dz8;
  logic [7:0]  sbc8, sc8, q8, r8;
  logic        start16, ready16, busy16, done16, dz16;
  logic [15:0] sbc16, sc16, q16, r16;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  div_seq_unsigned #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .SBC(sbc8), .SC(sc8),
    .ready(ready8), .busy(busy8), .done(done8), .dz(dz8), .Q(q8), .R(r8)
  );

  div_seq_unsigned #(.WIDTH(16), .STEP(2)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .SBC(sbc16), .SC(sc16),
    .ready(ready16), .busy(busy16), .done(done16), .dz(dz16), .Q(q16), .R(r16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // lat = number of rising edges after the accepting edge until done is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int l);
    @(negedge clk);
    sbc8 = a; sc8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    l = 0;
    while (!done8 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; sbc8 = '0; sc8 = '0;
    start16 = 1'b0; sbc16 = '0; sc16 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready8, 1);
    check("rst_busy",  busy8,  0);
    check("rst_done",  done8,  0);
    check("rst_dz",    dz8,    0);
    check("rst_q",     q8,     0);
    check("rst_r",     r8,     0);
    rst = 1'b0;

    // 200/7 with handshake and latency checks
    @(negedge clk);
    sbc8 = 8'd200; sc8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; sbc8 = 8'd1; sc8 = 8'd1;
    check("acc_busy",  busy8,  1);
    check("acc_ready", ready8, 0);
    check("acc_done",  done8,  0);
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    check("lat_200_7", lat, 8);
    check("q_200_7",  q8,  28);
    check("r_200_7",  r8,  4);
    check("dz_200_7", dz8, 0);

    run8(8'd5, 8'd9, lat);
    check("q_5_9", q8, 0);
    check("r_5_9", r8, 5);
    repeat (3) @(negedge clk);
    check("hold_done", done8, 1);
    check("hold_r",    r8,    5);

    run8(8'd255, 8'd1, lat);
    check("lat_255_1", lat, 8);
    check("q_255_1", q8, 255);
    check("r_255_1", r8, 0);

    // divide-by-zero: result registered on the accepting edge, no iteration
    run8(8'd13, 8'd0, lat);
    check("lat_dz", lat, 0);
    check("q_dz",  q8,  255);
    check("r_dz",  r8,  13);
    check("dz_dz", dz8, 1);

    // start while busy must be ignored
    @(negedge clk);
    sbc8 = 8'd200; sc8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin start8 = 1'b1; sbc8 = 8'd9; sc8 = 8'd3; end
      else start8 = 1'b0;
    end
    start8 = 1'b0;
    check("lat_ignore", lat, 8);
    check("q_ignore", q8, 28);
    check("r_ignore", r8, 4);
    check("dz_ignore", dz8, 0);

    // asynchronous reset in the middle of a division
    @(negedge clk);
    sbc8 = 8'd77; sc8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_ready", ready8, 1);
    check("mrst_busy",  busy8,  0);
    check("mrst_done",  done8,  0);
    check("mrst_q",     q8,     0);
    check("mrst_r",     r8,     0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'd100, 8'd10, lat);
    check("lat_100_10", lat, 8);
    check("q_100_10", q8, 10);
    check("r_100_10", r8, 0);

    // back-to-back with start held high across DONE
    @(negedge clk);
    sbc8 = 8'd200; sc8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_lat1", lat, 8);
    check("b2b_q1",   q8,  28);
    sbc8 = 8'd77; sc8 = 8'd5;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_gap_done", done8, 0);
    check("b2b_gap_busy", busy8, 1);
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_lat2", lat, 8);
    check("b2b_q2",   q8,  15);
    check("b2b_r2",   r8,  2);

    // 16-bit, two quotient bits per cycle
    @(negedge clk);
    sbc16 = 16'd50000; sc16 = 16'd123; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin @(negedge clk); lat++; end
    check("lat16", lat, 8);
    check("q16",   q16, 406);
    check("r16",   r16, 62);
    check("dz16",  dz16, 0);

    // reference-model sweep over a grid of dividend/divisor pairs
    for (int b = 0; b < 256; b += 17) begin
      for (int a = 0; a < 256; a += 7) begin
        logic [7:0]  ea, eb;
        logic [16:0] exp_v;
        ea = 8'(a);
        eb = 8'(b);
        run8(ea, eb, lat);
        if (eb == 8'd0) exp_v = {8'hFF, ea, 1'b1};
        else            exp_v = {ea / eb, ea % eb, 1'b0};
        check("sweep_lat", lat, (eb == 8'd0) ? 0 : 8);
        check("sweep_qrdz", {15'd0, q8, r8, dz8}, {15'd0, exp_v});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
